countdown_timer: RTL and testbench

- BCD minutes:seconds countdown timer (00:00 to 99:59) for the digital clock datapath.
- It is the down-counting counterpart of the up-counting digit counters: each second tick it decrements, propagating a borrow from the seconds units to the minutes tens.
- At 00:00 it raises a one-cycle done pulse and a held alarm flag for the display/buzzer logic.

---
 rtl/countdown_timer.sv | 181 ++++++++++++++++++
 tb/tb_countdown_timer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// BCD minutes:seconds countdown timer (00:00 .. 99:59).
// Decrements once per tick while running, borrowing from seconds units up to
// minutes tens. Reaching 00:00 emits a one-cycle done pulse and holds alarm
// until clr, a load, or AUTO_CLR_TICKS further ticks (0 disables auto-clear).
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous reset, active HIGH despite the name
//   tick                one-cycle 1 Hz enable
//   load                load clamped preset digits (ld_mm_t/ld_mm_u/ld_ss_t/ld_ss_u)
//   start/pause/clr     control strobes, priority clr > load > pause > start > tick
//   mm_t/mm_u/ss_t/ss_u current BCD digits
//   running             high in RUN
//   done                one-cycle pulse on reaching 00:00
//   alarm               high in EXPIRED
module countdown_timer #(
  parameter int unsigned AUTO_CLR_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_mm_t,
  input  logic [3:0] ld_mm_u,
  input  logic [2:0] ld_ss_t,
  input  logic [3:0] ld_ss_u,
  input  logic       start,
  input  logic       pause,
  input  logic       clr,
  output logic [3:0] mm_t,
  output logic [3:0] mm_u,
  output logic [2:0] ss_t,
  output logic [3:0] ss_u,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  // Counter only needs to hold 0 .. AUTO_CLR_TICKS-1.
  localparam int unsigned CW = (AUTO_CLR_TICKS > 1) ? $clog2(AUTO_CLR_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    mm_t_q, mm_t_d;
  logic [3:0]    mm_u_q, mm_u_d;
  logic [2:0]    ss_t_q, ss_t_d;
  logic [3:0]    ss_u_q, ss_u_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Clamped preset digits.
  logic [3:0] ld_mm_t_c, ld_mm_u_c, ld_ss_u_c;
  logic [2:0] ld_ss_t_c;

  always_comb begin
    ld_mm_t_c = (ld_mm_t > 4'd9) ? 4'd9 : ld_mm_t;
    ld_mm_u_c = (ld_mm_u > 4'd9) ? 4'd9 : ld_mm_u;
    ld_ss_t_c = (ld_ss_t > 3'd5) ? 3'd5 : ld_ss_t;
    ld_ss_u_c = (ld_ss_u > 4'd9) ? 4'd9 : ld_ss_u;
  end

  // Decremented count with borrow chain ss_u -> ss_t -> mm_u -> mm_t.
  logic [3:0] dec_mm_t, dec_mm_u, dec_ss_u;
  logic [2:0] dec_ss_t;
  logic       brw_ss_u, brw_ss_t, brw_mm_u;
  logic       count_zero, count_one;

  always_comb begin
    brw_ss_u = (ss_u_q == 4'd0);
    brw_ss_t = brw_ss_u && (ss_t_q == 3'd0);
    brw_mm_u = brw_ss_t && (mm_u_q == 4'd0);
    dec_ss_u = brw_ss_u ? 4'd9 : ss_u_q - 4'd1;
    dec_ss_t = brw_ss_u ? ((ss_t_q == 3'd0) ? 3'd5 : ss_t_q - 3'd1) : ss_t_q;
    dec_mm_u = brw_ss_t ? ((mm_u_q == 4'd0) ? 4'd9 : mm_u_q - 4'd1) : mm_u_q;
    // 00:00 never reaches RUN, so mm_t cannot underflow here.
    dec_mm_t = brw_mm_u ? mm_t_q - 4'd1 : mm_t_q;
    count_zero = (mm_t_q == 4'd0) && (mm_u_q == 4'd0) && (ss_t_q == 3'd0) && (ss_u_q == 4'd0);
    count_one  = (mm_t_q == 4'd0) && (mm_u_q == 4'd0) && (ss_t_q == 3'd0) && (ss_u_q == 4'd1);
  end

  // Next-state and next-output logic, evaluated in input priority order.
  always_comb begin
    state_d = state_q;
    mm_t_d  = mm_t_q;
    mm_u_d  = mm_u_q;
    ss_t_d  = ss_t_q;
    ss_u_d  = ss_u_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (clr) begin
      state_d = IDLE;
      mm_t_d  = 4'd0;
      mm_u_d  = 4'd0;
      ss_t_d  = 3'd0;
      ss_u_d  = 4'd0;
      cnt_d   = '0;
    end else if (load && (state_q != RUN)) begin
      mm_t_d = ld_mm_t_c;
      mm_u_d = ld_mm_u_c;
      ss_t_d = ld_ss_t_c;
      ss_u_d = ld_ss_u_c;
      cnt_d  = '0;
      if (state_q == EXPIRED) state_d = IDLE;
    end else if (pause) begin
      if ((state_q == RUN) || (state_q == PAUSE)) state_d = PAUSE;
    end else if (start) begin
      if (((state_q == IDLE) && !count_zero) || (state_q == PAUSE)) state_d = RUN;
    end else if (tick) begin
      case (state_q)
        RUN: begin
          mm_t_d = dec_mm_t;
          mm_u_d = dec_mm_u;
          ss_t_d = dec_ss_t;
          ss_u_d = dec_ss_u;
          if (count_one) begin
            state_d = EXPIRED;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
        EXPIRED: begin
          if (AUTO_CLR_TICKS != 0) begin
            if (cnt_q == CW'(AUTO_CLR_TICKS - 1)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    running_d = (state_d == RUN);
    alarm_d   = (state_d == EXPIRED);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      mm_t_q    <= 4'd0;
      mm_u_q    <= 4'd0;
      ss_t_q    <= 3'd0;
      ss_u_q    <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mm_t_q    <= mm_t_d;
      mm_u_q    <= mm_u_d;
      ss_t_q    <= ss_t_d;
      ss_u_q    <= ss_u_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      cnt_q     <= cnt_d;
    end
  end

  assign mm_t    = mm_t_q;
  assign mm_u    = mm_u_q;
  assign ss_t    = ss_t_q;
  assign ss_u    = ss_u_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random control traffic,
// checked against a reference model that keeps the count as total seconds.
module tb_countdown_timer;

  localparam int unsigned AUTO = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       rst_n, tick, load, pause, start, clr;
  logic [3:0] ld_mm_t, ld_mm_u, ld_ss_u;
  logic [2:0] ld_ss_t;
  logic [3:0] mm_t, mm_u, ss_u;
  logic [2:0] ss_t;
  logic       running, done, alarm;
  logic [17:0] dut_vec;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int m_secs, m_mode, m_cnt;
  bit m_done;

  countdown_timer #(.AUTO_CLR_TICKS(AUTO)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
    .ld_mm_t(ld_mm_t), .ld_mm_u(ld_mm_u), .ld_ss_t(ld_ss_t), .ld_ss_u(ld_ss_u),
    .start(start), .pause(pause), .clr(clr),
    .mm_t(mm_t), .mm_u(mm_u), .ss_t(ss_t), .ss_u(ss_u),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  assign dut_vec = {mm_t, mm_u, ss_t, ss_u, running, done, alarm};

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Expected output vector derived from total seconds.
  function automatic logic [17:0] exp_vec();
    int mm, ss;
    mm = m_secs / 60;
    ss = m_secs % 60;
    return {4'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10),
            1'(m_mode == M_RUN), 1'(m_done), 1'(m_mode == M_EXP)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = M_IDLE; m_cnt = 0; m_done = 0;
  endtask

  // One clock of the timer's rules, applied to the inputs sampled at the edge.
  task automatic model_update();
    m_done = 0;
    if (clr) begin
      m_secs = 0; m_mode = M_IDLE; m_cnt = 0;
    end else if (load && m_mode != M_RUN) begin
      m_secs = (min_i(int'(ld_mm_t), 9) * 10 + min_i(int'(ld_mm_u), 9)) * 60
             + min_i(int'(ld_ss_t), 5) * 10 + min_i(int'(ld_ss_u), 9);
      if (m_mode == M_EXP) m_mode = M_IDLE;
      m_cnt = 0;
    end else if (pause) begin
      if (m_mode == M_RUN || m_mode == M_PAUSE) m_mode = M_PAUSE;
    end else if (start) begin
      if ((m_mode == M_IDLE && m_secs != 0) || m_mode == M_PAUSE) m_mode = M_RUN;
    end else if (tick) begin
      if (m_mode == M_RUN) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_EXP; m_done = 1; m_cnt = 0;
        end
      end else if (m_mode == M_EXP && AUTO != 0) begin
        m_cnt++;
        if (m_cnt == int'(AUTO)) begin
          m_mode = M_IDLE; m_cnt = 0;
        end
      end
    end
  endtask

  // Advance one clock; strobes are dropped just after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    tick = 0; load = 0; pause = 0; start = 0; clr = 0;
  endtask

  task automatic set_load(input int a, input int b, input int c, input int d);
    ld_mm_t = 4'(a); ld_mm_u = 4'(b); ld_ss_t = 3'(c); ld_ss_u = 4'(d);
    load = 1;
  endtask

  task automatic test_reset();
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    vectors++;
    if (dut_vec !== 18'd0) begin
      $display("FAIL reset_hold: got %h expected %h", dut_vec, 18'd0); miscompares++;
    end
    rst_n = 0;
    step();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec()); miscompares++;
    end
  endtask

  task automatic test_basic();
    clr = 1; step();
    set_load(0, 1, 0, 0); step();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL basic_load: got %h expected %h", dut_vec, exp_vec()); miscompares++;
    end
    start = 1; step();
    tick = 1; step();
    vectors++;
    if ({mm_t, mm_u, ss_t, ss_u, running} !== {4'd0, 4'd0, 3'd5, 4'd9, 1'b1}) begin
      $display("FAIL basic_0059: got %h expected 00:59 running", dut_vec); miscompares++;
    end
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL basic_model: got %h expected %h", dut_vec, exp_vec()); miscompares++;
    end
  endtask

  task automatic test_borrow();
    clr = 1; step();
    set_load(1, 0, 0, 0); step();
    start = 1; step();
    tick = 1; step();
    vectors++;
    if ({mm_t, mm_u, ss_t, ss_u} !== {4'd0, 4'd9, 3'd5, 4'd9}) begin
      $display("FAIL borrow_0959: got %h expected 09:59", dut_vec); miscompares++;
    end
  endtask

  task automatic test_expire();
    int done_cycles;
    clr = 1; step();
    set_load(0, 0, 0, 2); step();
    start = 1; step();
    tick = 1; step();
    tick = 1; step();
    vectors++;
    if (dut_vec !== {4'd0, 4'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1}) begin
      $display("FAIL expire_zero: got %h expected 0000 done alarm", dut_vec); miscompares++;
    end
    done_cycles = 1;
    step();
    if (done) done_cycles++;
    vectors++;
    if (done_cycles != 1) begin
      $display("FAIL expire_done_width: got %0d cycles expected 1", done_cycles); miscompares++;
    end
    for (int i = 0; i < int'(AUTO); i++) begin
      tick = 1; step();
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL expire_autoclr_%0d: got %h expected %h", i, dut_vec, exp_vec()); miscompares++;
      end
    end
    vectors++;
    if (alarm !== 1'b0 || running !== 1'b0) begin
      $display("FAIL expire_idle: got alarm=%b running=%b expected 0 0", alarm, running); miscompares++;
    end
  endtask

  task automatic test_pause_tick();
    clr = 1; step();
    set_load(0, 0, 0, 5); step();
    start = 1; step();
    tick = 1; step();
    pause = 1; tick = 1; step();
    vectors++;
    if ({ss_u, running} !== {4'd4, 1'b0}) begin
      $display("FAIL pause_hold: got %h expected 00:04 paused", dut_vec); miscompares++;
    end
    start = 1; step();
    tick = 1; step();
    vectors++;
    if ({ss_u, running} !== {4'd3, 1'b1}) begin
      $display("FAIL pause_resume: got %h expected 00:03 running", dut_vec); miscompares++;
    end
  endtask

  task automatic test_clamp();
    clr = 1; step();
    set_load(15, 5, 7, 12); step();
    vectors++;
    if ({mm_t, mm_u, ss_t, ss_u} !== {4'd9, 4'd5, 3'd5, 4'd9}) begin
      $display("FAIL clamp_9559: got %h expected 95:59", dut_vec); miscompares++;
    end
    set_load(0, 0, 0, 0); step();
    start = 1; step();
    tick = 1; step();
    vectors++;
    if (dut_vec !== 18'd0) begin
      $display("FAIL start_zero: got %h expected %h", dut_vec, 18'd0); miscompares++;
    end
  endtask

  task automatic test_clr_load();
    clr = 1; step();
    set_load(0, 3, 2, 2); step();
    start = 1; step();
    tick = 1; step();
    vectors++;
    if ({mm_t, mm_u, ss_t, ss_u, running} !== {4'd0, 4'd3, 3'd2, 4'd1, 1'b1}) begin
      $display("FAIL clr_setup_0321: got %h expected 03:21 running", dut_vec); miscompares++;
    end
    clr = 1; set_load(4, 4, 4, 4); step();
    vectors++;
    if (dut_vec !== 18'd0) begin
      $display("FAIL clr_over_load: got %h expected %h", dut_vec, 18'd0); miscompares++;
    end
  endtask

  task automatic test_async_reset();
    clr = 1; step();
    set_load(0, 0, 3, 0); step();
    start = 1; step();
    tick = 1; step();
    #2;
    rst_n = 1;
    #1;
    vectors++;
    if (dut_vec !== 18'd0) begin
      $display("FAIL async_reset: got %h expected %h", dut_vec, 18'd0); miscompares++;
    end
    #1;
    rst_n = 0;
    model_reset();
    step();
    vectors++;
    if (dut_vec !== exp_vec()) begin
      $display("FAIL async_reset_after: got %h expected %h", dut_vec, exp_vec()); miscompares++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      clr   = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 5);
      pause = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 12);
      tick  = ($urandom_range(0, 99) < 45);
      ld_mm_t = 4'($urandom_range(0, 2));
      ld_mm_u = 4'($urandom_range(0, 15));
      ld_ss_t = 3'($urandom_range(0, 7));
      ld_ss_u = 4'($urandom_range(0, 15));
      step();
      vectors++;
      if (dut_vec !== exp_vec()) begin
        $display("FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec()); miscompares++;
      end
    end
  endtask

  initial begin
    rst_n = 1; tick = 0; load = 0; pause = 0; start = 0; clr = 0;
    ld_mm_t = 0; ld_mm_u = 0; ld_ss_t = 0; ld_ss_u = 0;
    model_reset();
    test_reset();
    test_basic();
    test_borrow();
    test_expire();
    test_pause_tick();
    test_clamp();
    test_clr_load();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
